// File: rtl/vga_rect_fill_pkg.sv
// Shared framebuffer geometry, address packing and fill-engine state encoding.
// Used by the fill engine, its clipper and the bus interface.
package vga_rect_fill_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int ADDR_W   = 19;
  localparam int RGB_W    = 12;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Latched, already-clipped command; y0 lives in the row counter.
  typedef struct packed {
    logic [CNT_W-1:0] x0;
    logic [CNT_W-1:0] cx1;
    logic [CNT_W-1:0] cy1;
    logic [RGB_W-1:0] color;
  } rect_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/vga_rect_fill_if.sv
// Command and framebuffer write-port bundle of the rectangle fill engine.
// slave = engine side, master = command source / memory side.
interface vga_rect_fill_if;
  import vga_rect_fill_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_x0;
  logic [CNT_W-1:0]  cmd_x1;
  logic [CNT_W-1:0]  cmd_y0;
  logic [CNT_W-1:0]  cmd_y1;
  logic [RGB_W-1:0]  cmd_color;
  logic              mem_we;
  logic              mem_wready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, mem_wready,
    output cmd_ready, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, mem_wready,
    input  cmd_ready, mem_we, mem_addr, mem_wdata, busy, done
  );

endinterface

// File: rtl/vga_rect_fill_rect_clip.sv
// Clips an inclusive rectangle to the visible area; combinational, no handshake.
// Bounds are never swapped: reversed or off-screen rectangles report empty.
module rect_clip
  import vga_rect_fill_pkg::*;
(
  input  logic [CNT_W-1:0] x0,
  input  logic [CNT_W-1:0] x1,
  input  logic [CNT_W-1:0] y0,
  input  logic [CNT_W-1:0] y1,
  output logic [CNT_W-1:0] cx1,
  output logic [CNT_W-1:0] cy1,
  output logic             empty
);

  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(V_ACTIVE - 1);

  always_comb begin
    cx1   = (x1 > X_MAX) ? X_MAX : x1;
    cy1   = (y1 > Y_MAX) ? Y_MAX : y1;
    empty = (x0 > cx1) || (y0 > cy1);
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: one clipped command in, one raster-order write per cycle out.
// First write one cycle after accept; mem_wready=0 freezes the write port; done one cycle after last write.
module vga_rect_fill
  import vga_rect_fill_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  vga_rect_fill_if.slave    bus
);

  state_t            state_q, state_d;
  rect_t             cmd_q, cmd_d;
  logic [CNT_W-1:0]  x_q, x_d;
  logic [CNT_W-1:0]  y_q, y_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  clip_cx1;
  logic [CNT_W-1:0]  clip_cy1;
  logic              clip_empty;

  rect_clip u_clip (
    .x0    (bus.cmd_x0),
    .x1    (bus.cmd_x1),
    .y0    (bus.cmd_y0),
    .y1    (bus.cmd_y1),
    .cx1   (clip_cx1),
    .cy1   (clip_cy1),
    .empty (clip_empty)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    x_d      = x_q;
    y_d      = y_q;
    wdata_d  = wdata_q;
    mem_we_d = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d = '{x0: bus.cmd_x0, cx1: clip_cx1, cy1: clip_cy1, color: bus.cmd_color};
          if (clip_empty) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = FILL;
            x_d      = bus.cmd_x0;
            y_d      = bus.cmd_y0;
            wdata_d  = {4'h0, bus.cmd_color};
            mem_we_d = 1'b1;
          end
        end
      end
      FILL: begin
        mem_we_d = 1'b1;
        // Counters only move on an accepted write, so a stall freezes the port.
        if (bus.mem_wready) begin
          if (x_q == cmd_q.cx1) begin
            if (y_q == cmd_q.cy1) begin
              state_d  = DONE;
              mem_we_d = 1'b0;
              done_d   = 1'b1;
            end else begin
              x_d = cmd_q.x0;
              y_d = y_q + 10'd1;
            end
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mem_we_q <= 1'b0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mem_we_q <= mem_we_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  end

  // y is bounded by the clipped cy1 (<=479), so dropping bit 9 is lossless.
  assign bus.mem_addr  = pack_addr(x_q, y_q[Y_W-1:0]);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cmd_ready = (state_q == IDLE);

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Framebuffer write engine. It fills axis-aligned rectangles of one 12-bit colour into the 640x480 framebuffer that the VGA scan-out reads. It accepts one rectangle command over a valid/ready handshake, clips it to the visible area and issues one write per cycle in raster order. Addresses and data use the same packing as the display read side: address {y[8:0], x[9:0]}, RGB in data[11:0].

## Interface
- H_ACTIVE, 640: visible width in pixels; x range 0..639.
- V_ACTIVE, 480: visible height in lines; y range 0..479.
- clk  in  1  pixel-domain clock, shared with scan-out.
- rst  in  1  asynchronous, active-high reset (one clock; reset asynchronous and active-high).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle and able to accept a command.
- cmd_x0, cmd_x1  in  10  inclusive column bounds.
- cmd_y0, cmd_y1  in  10  inclusive row bounds.
- cmd_color  in  12  RGB444 fill colour.
- mem_we  out  1  write request.
- mem_wready  in  1  memory accepts the write this cycle.
- mem_addr  out  19  {y[8:0], x[9:0]}.
- mem_wdata  out  16  {4'h0, color}.
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle pulse at command completion.

## Operation
- States: IDLE, FILL, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch the clipped command and the colour.
  - Go to FILL if the clipped rectangle is non-empty, else go to DONE.
- Clipping:
  - cx1 = min(x1, H_ACTIVE-1); cy1 = min(y1, V_ACTIVE-1).
  - The rectangle is empty if x0>cx1 or y0>cy1. This covers x0>=640, y0>=480 and reversed bounds.
  - Reversed bounds are not swapped.
- FILL:
  - Keep counters x and y, starting at (x0, y0). mem_we=1.
  - A write is accepted in any cycle with mem_we&&mem_wready.
  - On each accepted write: if x==cx1, set x=x0 and y=y+1; otherwise x=x+1.
  - If the accepted write is at (cx1, cy1), go to DONE.
  - While mem_wready=0, mem_addr, mem_wdata and mem_we hold steady.
- DONE:
  - done=1 and mem_we=0 for exactly one cycle, then go to IDLE.
- cmd_* inputs are ignored whenever cmd_ready=0.
- Arithmetic:
  - Counters are 10 bits, and comparisons are unsigned.
  - y never exceeds 479, so y[8:0] is lossless in the address.
- Reset:
  - Asynchronous; it may occur mid-FILL.
  - Forces IDLE immediately: mem_we=0, done=0, busy=0, cmd_ready=1, mem_addr=0, mem_wdata=0.
  - The aborted command produces no done pulse. Pixels already written stay written.

## Timing
- mem_we, mem_addr, mem_wdata, done and busy are registered. cmd_ready is decoded from the state register.
- Command accepted at edge T: first mem_we=1 with address {y0,x0} in cycle T+1.
- Throughput is 1 pixel/cycle with mem_wready held at 1. A WxH rectangle occupies W*H FILL cycles plus stall cycles.
- Last write accepted in cycle L: done=1 in L+1, cmd_ready=1 in L+2.
- Empty command accepted at T: done=1 in T+1, cmd_ready=1 in T+2, and no writes are issued.
- Row wrap costs no bubble cycle.

## Structure
- Shared package / vga_parameter include holds:
  - H_ACTIVE=640 and V_ACTIVE=480.
  - Address packing widths: X_W=10, Y_W=9, ADDR_W=19.
  - The RGB width of 12 and the state encodings IDLE=2'd0, FILL=2'd1, DONE=2'd2.
- One combinational sub-module, rect_clip: takes x0, x1, y0, y1 and produces cx1, cy1 and empty. It is reusable by future line and blit engines.
- The top level contains the FSM, the counters and the write-port registers.

## Test plan
- Single pixel (10,20)-(10,20), colour 12'hF00: exactly one write, mem_addr=19'h0500A, mem_wdata=16'h0F00. done in the cycle after acceptance.
- Full screen (0,0)-(639,479), colour 12'h0F0 with mem_wready=1:
  - exactly 307200 writes;
  - first address 19'h00000, last address 19'h77E7F;
  - row wrap from 19'h0027F to 19'h00400 in consecutive cycles.
- Clipped (630,470)-(700,500): exactly 100 writes, addresses x 630..639 and y 470..479. No address has x>639 or y>479.
- Empty (5,0)-(3,0) and (700,0)-(710,5): zero writes, done at T+1, cmd_ready=1 at T+2.
- Backpressure on 4x1 at (0,0): drop mem_wready for 3 cycles on the second pixel.
  - mem_addr holds at 19'h00001 with mem_we=1.
  - Exactly 4 accepted writes in total, and done appears 1 cycle after the 4th.
- Reset mid-FILL of (0,0)-(99,99): assert rst asynchronously between clock edges.
  - mem_we=0 immediately and no done pulse.
  - A new command after reset starts cleanly at its own x0,y0.
